// File: rtl/kbd_event_ctrl_if.sv
// Byte-input / event-read bundle between the PS/2 side, the device register and the event controller.
interface kbd_event_ctrl_if #(
  parameter int unsigned PTR_W = 3
);
  logic             ps2_valid;
  logic [7:0]       ps2_data;
  logic             rd_req;
  logic             clr_overflow;
  logic [15:0]      rd_data;
  logic             rd_empty;
  logic [PTR_W:0]   fifo_count;
  logic             overflow;

  modport master (
    output ps2_valid, ps2_data, rd_req, clr_overflow,
    input  rd_data, rd_empty, fifo_count, overflow
  );

  modport slave (
    input  ps2_valid, ps2_data, rd_req, clr_overflow,
    output rd_data, rd_empty, fifo_count, overflow
  );
endinterface

// File: rtl/kbd_event_ctrl.sv
// Scan-code prefix decoder (E0/F0) feeding a first-word-fall-through key event FIFO.
module kbd_event_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  kbd_event_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t            state_q, state_d;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [PTR_W:0]    count;
  logic              empty, full, pop, push, push_ok, drop;
  logic [15:0]       evt;
  logic              is_e0, is_f0, is_err;

  assign is_e0  = (bus.ps2_data == 8'hE0);
  assign is_f0  = (bus.ps2_data == 8'hF0);
  assign is_err = (bus.ps2_data == 8'h00) || (bus.ps2_data == 8'hFF);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    evt     = '0;
    if (bus.ps2_valid) begin
      state_d = IDLE;
      unique case (state_q)
        IDLE: begin
          if (is_e0)       state_d = EXT;
          else if (is_f0)  state_d = BRK;
          else if (!is_err) begin
            push = 1'b1;
            evt  = {2'b10, 6'b0, bus.ps2_data};
          end
        end
        EXT: begin
          if (is_f0)       state_d = EXT_BRK;
          else if (is_e0)  state_d = EXT;
          else if (!is_err) begin
            push = 1'b1;
            evt  = {2'b11, 6'b0, bus.ps2_data};
          end
        end
        BRK: begin
          if (!(is_e0 || is_f0 || is_err)) begin
            push = 1'b1;
            evt  = {2'b00, 6'b0, bus.ps2_data};
          end
        end
        EXT_BRK: begin
          if (!(is_e0 || is_f0 || is_err)) begin
            push = 1'b1;
            evt  = {2'b01, 6'b0, bus.ps2_data};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  // Pop is qualified by the pre-edge empty flag; a pop at full frees the slot for a same-cycle push.
  assign pop     = bus.rd_req && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q;
    if (bus.clr_overflow) overflow_d = 1'b0;
    if (drop)             overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= evt;
  end

  assign bus.rd_data    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign bus.rd_empty   = empty;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/kbd_event_ctrl.md
Name: kbd_event_ctrl

Overview:
- Sequencing controller between the PS/2 byte receiver and the CPU-visible keyboard device register.
- Consumes raw scan-code bytes and decodes make, break and E0-extended prefix sequences with a prefix state machine.
- Queues complete key events in a first-word-fall-through FIFO that the device read path drains one event per request.
- Replaces single-event latching, so no key event is lost while software is slow to read.

Parameters:
- FIFO_DEPTH, 8, number of event entries; must be a power of 2, minimum 2.
- PTR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ps2_valid  input  1  one-cycle strobe: ps2_data holds a new received byte.
- ps2_data  input  8  scan-code byte from the PS/2 receiver.
- rd_req  input  1  pop the head event this cycle; ignored when empty.
- clr_overflow  input  1  clears the sticky overflow flag.
- rd_data  output  16  head event; 16'h0000 when empty.
- rd_empty  output  1  FIFO holds no events.
- fifo_count  output  PTR_W+1  number of queued events, 0..FIFO_DEPTH.
- overflow  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - Decoder state goes to IDLE; read and write pointers clear.
  - Outputs: rd_data=0, rd_empty=1, fifo_count=0, overflow=0.
  - Reset mid-sequence discards any partial prefix and all queued events.
- Event format:
  - [15] keydown (1 = make, 0 = break).
  - [14] extended (the sequence began with E0).
  - [13:8] = 0.
  - [7:0] = final scan code.
- Decoder FSM advances only on cycles with ps2_valid=1. Prefix bytes are E0 and F0; error bytes are 00 and FF.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - 00/FF -> IDLE, byte dropped.
    - Any other code -> push {1,0,6'b0,code}; go to IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay in EXT.
    - 00/FF -> IDLE, no push.
    - Any other code -> push {1,1,6'b0,code}; go to IDLE.
  - BRK:
    - Any other code -> push {0,0,6'b0,code}; go to IDLE.
    - E0, F0, 00 or FF -> IDLE, no push (malformed sequence).
  - EXT_BRK:
    - Any other code -> push {0,1,6'b0,code}; go to IDLE.
    - E0, F0, 00 or FF -> IDLE, no push.
- FIFO:
  - Push is registered: the event is visible on rd_data/rd_empty/fifo_count in the cycle after the final byte's ps2_valid.
  - rd_data is combinational from the head entry (first-word fall-through).
  - rd_req with rd_empty=0: head advances at the clock edge; the next entry (or 0) appears in the following cycle.
  - rd_req with rd_empty=1: no effect.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count = wr_ptr - rd_ptr using PTR_W+1-bit pointers.
- Boundary conditions:
  - Push and pop in the same cycle when not empty: both occur; count unchanged.
  - Push and pop in the same cycle when full: pop frees a slot, push is accepted; overflow is not set.
  - Push when full with no pop: event dropped, overflow <= 1, pointers unchanged.
  - Push when empty: accepted; the same-cycle rd_req is ignored because the pop uses the pre-edge empty flag.
- Overflow flag:
  - clr_overflow=1 clears overflow on the next edge.
  - If a drop occurs in the same cycle as clr_overflow, set wins and overflow = 1.
- No combinational path from ps2_data or ps2_valid to any output.

Test Plan:
- Bytes 1C, then F0,1C (one per valid strobe) -> two events, 16'h801C then 16'h001C; fifo_count steps 1 then 2; rd_req twice drains to rd_empty=1, rd_data=0.
- E0,75 then E0,F0,75 -> events 16'hC075 and 16'h4075 in order.
- Malformed stream F0,E0,1C -> only 16'h801C queued: F0,E0 abort to IDLE and 1C decodes as a fresh make. Byte 00 in IDLE -> nothing queued.
- With FIFO_DEPTH=8: push 9 make codes (16..1E) with no reads -> fifo_count=8, overflow=1, head 16'h8016, last entry 16'h801D. Then clr_overflow -> overflow=0 with contents intact.
- At full, final byte and rd_req in the same cycle -> count stays 8, overflow stays 0, head advances to the second entry. Pop and push at count 3 -> count stays 3.
- After E0,F0, pulse reset=0 asynchronously mid-cycle with 2 events queued -> outputs zero and rd_empty=1 immediately. Then byte 75 -> 16'h8075 (not extended, not break).
